// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage pipelined datapath (RD -> EX) with an internal
// register file, an eight-function ALU and a registered result/flag port.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   micro-op handshake from the instruction sequencer
//   in_alu_sel          ALU function (ADD SUB AND OR XOR NOT SHL SHR)
//   in_imm_sel, in_imm  operand B source: 0 = register rs2, 1 = immediate
//   in_rs1, in_rs2      source register addresses
//   in_rd, in_we        destination register and its write enable
//   out_valid/out_ready result handshake towards the consumer
//   out_result          ALU result
//   out_carry, out_zero carry flag, result-is-zero flag
//   out_rd              destination register of the presented result
//
// Configuration macro: PIPE_DATAPATH_FWD_EN
//   defined   : the EX result is forwarded into the RD stage, no stalls
//   undefined : no forwarding; a read-after-write hazard against the op in
//               EX holds in_ready low for one cycle and a bubble enters EX
//
// Handshake rules (both ports): a transfer happens at a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer. While out_valid && !out_ready the out_* payload
// is frozen, the whole pipeline holds and in_ready is low.
module pipe_datapath #(
  parameter int WIDTH     = 8,
  parameter int REG_COUNT = 8,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alu_sel,
  input  logic             in_imm_sel,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [AW-1:0]    out_rd
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  logic [WIDTH-1:0] regs [REG_COUNT];

  // RD/EX pipeline register
  logic             ex_valid;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [2:0]       ex_alu_sel;
  logic [AW-1:0]    ex_rd;
  logic             ex_we;

  logic             adv;
  logic             hazard;
  logic             accept;
  logic             fwd_rs1;
  logic             fwd_rs2;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] op_b;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_zero;

  // The whole pipeline moves only when the output register can take a value.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard;
  assign accept   = in_valid && in_ready;

`ifdef PIPE_DATAPATH_FWD_EN
  assign fwd_rs1 = ex_valid && ex_we && (ex_rd == in_rs1);
  assign fwd_rs2 = ex_valid && ex_we && (ex_rd == in_rs2);
  assign hazard  = 1'b0;
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
  // The register file is written at the same edge the dependent op would be
  // accepted, so holding it off one cycle lets it read the new value.
  assign hazard  = in_valid && ex_valid && ex_we &&
                   ((ex_rd == in_rs1) || (!in_imm_sel && (ex_rd == in_rs2)));
`endif

  // RD stage: register read, forwarding, operand B select
  assign rs1_val = fwd_rs1 ? alu_res : regs[in_rs1];
  assign rs2_val = fwd_rs2 ? alu_res : regs[in_rs2];
  assign op_b    = in_imm_sel ? in_imm : rs2_val;

  // EX stage ALU
  assign sum_ext = {1'b0, ex_a} + {1'b0, ex_b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ex_alu_sel)
      ALU_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      ALU_SUB: begin
        alu_res   = ex_a - ex_b;
        alu_carry = (ex_a >= ex_b);   // carry means "no borrow"
      end
      ALU_AND: alu_res = ex_a & ex_b;
      ALU_OR:  alu_res = ex_a | ex_b;
      ALU_XOR: alu_res = ex_a ^ ex_b;
      ALU_NOT: alu_res = ~ex_a;
      ALU_SHL: begin
        alu_res   = {ex_a[WIDTH-2:0], 1'b0};
        alu_carry = ex_a[WIDTH-1];
      end
      ALU_SHR: begin
        alu_res   = {1'b0, ex_a[WIDTH-1:1]};
        alu_carry = ex_a[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // Pipeline and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_alu_sel <= '0;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_rd     <= '0;
    end else if (adv) begin
      // A cycle without an accepted op loads a bubble.
      ex_valid <= accept;
      if (accept) begin
        ex_a       <= rs1_val;
        ex_b       <= op_b;
        ex_alu_sel <= in_alu_sel;
        ex_rd      <= in_rd;
        ex_we      <= in_we;
      end
      out_valid <= ex_valid;
      if (ex_valid) begin
        out_result <= alu_res;
        out_carry  <= alu_carry;
        out_zero   <= alu_zero;
        out_rd     <= ex_rd;
      end
    end
  end

  // Register file: write-back from EX at the same edge the result is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (adv && ex_valid && ex_we) begin
      regs[ex_rd] <= alu_res;
    end
  end

endmodule

// File: tb/tb_pipe_datapath.sv
module tb_pipe_datapath;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

`ifdef PIPE_DATAPATH_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT 8-bit / 8 regs ----------------
  logic       in_valid, in_ready, in_imm_sel, in_we;
  logic [2:0] in_alu_sel;
  logic [7:0] in_imm;
  logic [2:0] in_rs1, in_rs2, in_rd;
  logic       out_valid, out_ready, out_carry, out_zero;
  logic [7:0] out_result;
  logic [2:0] out_rd;

  pipe_datapath #(.WIDTH(8), .REG_COUNT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_sel(in_alu_sel), .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
    .out_rd(out_rd)
  );

  // ---------------- DUT 16-bit / 16 regs ----------------
  logic        p_in_valid, p_in_ready, p_in_imm_sel, p_in_we;
  logic [2:0]  p_in_alu_sel;
  logic [15:0] p_in_imm;
  logic [3:0]  p_in_rs1, p_in_rs2, p_in_rd;
  logic        p_out_valid, p_out_ready, p_out_carry, p_out_zero;
  logic [15:0] p_out_result;
  logic [3:0]  p_out_rd;

  pipe_datapath #(.WIDTH(16), .REG_COUNT(16)) dut_p (
    .clk(clk), .rst(rst),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_alu_sel(p_in_alu_sel), .in_imm_sel(p_in_imm_sel), .in_imm(p_in_imm),
    .in_rs1(p_in_rs1), .in_rs2(p_in_rs2), .in_rd(p_in_rd), .in_we(p_in_we),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_result(p_out_result), .out_carry(p_out_carry), .out_zero(p_out_zero),
    .out_rd(p_out_rd)
  );

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  int stall_cnt;

  typedef struct {
    logic [2:0] sel;
    logic       isel;
    logic [7:0] imm;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [7:0] er;
    logic       ec;
    logic       ez;
  } op_t;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic [2:0] rd;
    int         cyc;
  } obs_t;

  op_t   ops_q[$];
  obs_t  obs_q[$];
  obs_t  mon_o;

  logic [15:0] mregs [16];
  logic [21:0] exp_q[$];
  logic [21:0] p_obs_q[$];

  function automatic op_t mk(input logic [2:0] sel, input logic isel,
                             input logic [7:0] imm, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic [2:0] rd,
                             input logic [7:0] er, input logic ec,
                             input logic ez);
    op_t o;
    o.sel = sel; o.isel = isel; o.imm = imm; o.rs1 = rs1; o.rs2 = rs2;
    o.rd = rd; o.er = er; o.ec = ec; o.ez = ez;
    return o;
  endfunction

  // Output monitors: sample mid-cycle, after all drivers have settled.
  always @(negedge clk) begin
    #3;
    if (rst && out_valid && out_ready) begin
      mon_o.res = out_result;
      mon_o.c   = out_carry;
      mon_o.z   = out_zero;
      mon_o.rd  = out_rd;
      mon_o.cyc = cyc;
      obs_q.push_back(mon_o);
    end
    if (rst && p_out_valid && p_out_ready)
      p_obs_q.push_back({p_out_rd, p_out_carry, p_out_zero, p_out_result});
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after acceptance,
  // leaving in_valid high so the next call can follow back-to-back.
  task automatic send(input op_t o);
    bit done;
    done = 0;
    in_alu_sel = o.sel; in_imm_sel = o.isel; in_imm = o.imm;
    in_rs1 = o.rs1; in_rs2 = o.rs2; in_rd = o.rd; in_we = 1'b1;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (in_ready) done = 1;
      else stall_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_accept: in_ready=%0b, required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_obs(input int n);
    for (int k = 0; k < 60 && obs_q.size() < n; k++) @(negedge clk);
    checks++;
    if (obs_q.size() != n) begin
      failures++;
      $display("FAIL obs_count: got %0d results, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic run_ops();
    obs_q.delete();
    stall_cnt = 0;
    foreach (ops_q[i]) send(ops_q[i]);
    idle(2);
    wait_obs(ops_q.size());
  endtask

  task automatic send_p(input logic [2:0] sel, input logic isel,
                        input logic [15:0] imm, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [3:0] rd);
    bit done;
    done = 0;
    p_in_alu_sel = sel; p_in_imm_sel = isel; p_in_imm = imm;
    p_in_rs1 = rs1; p_in_rs2 = rs2; p_in_rd = rd; p_in_we = 1'b1;
    p_in_valid = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      p_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (p_in_ready) done = 1;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL p_send_accept: p_in_ready=%0b, required 1 within 60 cycles", p_in_ready);
    end
  endtask

  // Table of OR rX = rX | 0 for every register: each must read back zero.
  task automatic load_zero_reads();
    ops_q.delete();
    for (int r = 0; r < 8; r++)
      ops_q.push_back(mk(OP_OR, 1'b1, 8'h00, 3'(r), 3'd0, 3'(r), 8'h00, 1'b0, 1'b1));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_alu_sel = '0; in_imm_sel = 1'b0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = 1'b0; out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_alu_sel = '0; p_in_imm_sel = 1'b0; p_in_imm = '0;
    p_in_rs1 = '0; p_in_rs2 = '0; p_in_rd = '0; p_in_we = 1'b0; p_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_carry, out_zero, out_rd, out_result} !== 14'd0) begin
      failures++;
      $display("FAIL reset_out: got v=%0b c=%0b z=%0b rd=%0d res=%h, required all 0",
               out_valid, out_carry, out_zero, out_rd, out_result);
    end
    checks++;
    if ({p_out_valid, p_out_carry, p_out_zero, p_out_rd, p_out_result} !== 23'd0) begin
      failures++;
      $display("FAIL reset_out_p: got v=%0b res=%h rd=%0d, required all 0",
               p_out_valid, p_out_result, p_out_rd);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, p_in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b/%0b, required 1/1", in_ready, p_in_ready);
    end
    @(negedge clk);
    load_zero_reads();
    run_ops();
    for (int i = 0; i < ops_q.size() && obs_q.size() > 0; i++) begin
      obs_t o;
      o = obs_q.pop_front();
      checks++;
      if ({o.rd, o.c, o.z, o.res} !== {ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er}) begin
        failures++;
        $display("FAIL reset_regs[%0d]: got rd=%0d c=%0b z=%0b res=%h, required rd=%0d c=%0b z=%0b res=%h",
                 i, o.rd, o.c, o.z, o.res, ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er);
      end
    end
  endtask

  task automatic test_reset_write();
    int prev;
    ops_q.delete();
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h05, 3'd0, 3'd0, 3'd1, 8'h05, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h03, 3'd0, 3'd0, 3'd2, 8'h03, 1'b0, 1'b0));
    run_ops();
    checks++;
    if (stall_cnt != 0) begin
      failures++;
      $display("FAIL write_stalls: got %0d stall cycles, required 0", stall_cnt);
    end
    prev = 0;
    for (int i = 0; i < ops_q.size() && obs_q.size() > 0; i++) begin
      obs_t o;
      o = obs_q.pop_front();
      checks++;
      if ({o.rd, o.c, o.z, o.res} !== {ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er}) begin
        failures++;
        $display("FAIL write[%0d]: got rd=%0d c=%0b z=%0b res=%h, required rd=%0d c=%0b z=%0b res=%h",
                 i, o.rd, o.c, o.z, o.res, ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er);
      end
      if (i > 0) begin
        checks++;
        if (o.cyc != prev + 1) begin
          failures++;
          $display("FAIL write_throughput[%0d]: got cycle %0d, required %0d", i, o.cyc, prev + 1);
        end
      end
      prev = o.cyc;
    end
  endtask

  task automatic test_forwarding();
    int exp_stall;
    exp_stall = (FWD != 0) ? 0 : 2;
    ops_q.delete();
    // r1 = 5, r2 = 3 at entry
    ops_q.push_back(mk(OP_ADD, 1'b0, 8'h00, 3'd1, 3'd2, 3'd3, 8'h08, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_SUB, 1'b1, 8'h08, 3'd3, 3'd0, 3'd4, 8'h00, 1'b1, 1'b1));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h09, 3'd0, 3'd0, 3'd5, 8'h09, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h01, 3'd0, 3'd0, 3'd6, 8'h01, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h00, 3'd5, 3'd0, 3'd7, 8'h09, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h10, 3'd0, 3'd0, 3'd3, 8'h10, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b0, 8'h00, 3'd1, 3'd3, 3'd4, 8'h15, 1'b0, 1'b0));
    run_ops();
    checks++;
    if (stall_cnt != exp_stall) begin
      failures++;
      $display("FAIL fwd_stalls: got %0d stall cycles, required %0d", stall_cnt, exp_stall);
    end
    for (int i = 0; i < ops_q.size() && obs_q.size() > 0; i++) begin
      obs_t o;
      o = obs_q.pop_front();
      checks++;
      if ({o.rd, o.c, o.z, o.res} !== {ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er}) begin
        failures++;
        $display("FAIL fwd[%0d]: got rd=%0d c=%0b z=%0b res=%h, required rd=%0d c=%0b z=%0b res=%h",
                 i, o.rd, o.c, o.z, o.res, ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er);
      end
    end
  endtask

  task automatic test_flags();
    ops_q.delete();
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'hFF, 3'd0, 3'd0, 3'd5, 8'hFF, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h01, 3'd5, 3'd0, 3'd6, 8'h00, 1'b1, 1'b1));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h81, 3'd0, 3'd0, 3'd7, 8'h81, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_SHL, 1'b1, 8'h00, 3'd7, 3'd0, 3'd6, 8'h02, 1'b1, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h01, 3'd0, 3'd0, 3'd6, 8'h01, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_SHR, 1'b1, 8'h00, 3'd6, 3'd0, 3'd5, 8'h00, 1'b1, 1'b1));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h03, 3'd0, 3'd0, 3'd7, 8'h03, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_SUB, 1'b1, 8'h05, 3'd7, 3'd0, 3'd5, 8'hFE, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_AND, 1'b0, 8'h00, 3'd1, 3'd2, 3'd5, 8'h01, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_OR,  1'b0, 8'h00, 3'd1, 3'd2, 3'd5, 8'h07, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_XOR, 1'b0, 8'h00, 3'd1, 3'd2, 3'd5, 8'h06, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_NOT, 1'b1, 8'h00, 3'd1, 3'd0, 3'd5, 8'hFA, 1'b0, 1'b0));
    run_ops();
    for (int i = 0; i < ops_q.size() && obs_q.size() > 0; i++) begin
      obs_t o;
      o = obs_q.pop_front();
      checks++;
      if ({o.rd, o.c, o.z, o.res} !== {ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er}) begin
        failures++;
        $display("FAIL flags[%0d]: got rd=%0d c=%0b z=%0b res=%h, required rd=%0d c=%0b z=%0b res=%h",
                 i, o.rd, o.c, o.z, o.res, ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er);
      end
    end
  endtask

  task automatic test_backpressure();
    ops_q.delete();
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h11, 3'd0, 3'd0, 3'd5, 8'h11, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_ADD, 1'b1, 8'h22, 3'd0, 3'd0, 3'd6, 8'h22, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_OR,  1'b1, 8'h00, 3'd6, 3'd0, 3'd7, 8'h22, 1'b0, 1'b0));
    ops_q.push_back(mk(OP_OR,  1'b1, 8'h00, 3'd5, 3'd0, 3'd4, 8'h11, 1'b0, 1'b0));
    obs_q.delete();
    out_ready = 1'b0;
    send(ops_q[0]);
    send(ops_q[1]);
    // Offer the third op while the consumer stalls.
    in_alu_sel = ops_q[2].sel; in_imm_sel = ops_q[2].isel; in_imm = ops_q[2].imm;
    in_rs1 = ops_q[2].rs1; in_rs2 = ops_q[2].rs2; in_rd = ops_q[2].rd; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, out_rd, out_carry, out_zero, out_result} !==
          {1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h11}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got in_ready=%0b v=%0b rd=%0d res=%h, required 0 1 5 11",
                 c, in_ready, out_valid, out_rd, out_result);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(ops_q[2]);
    send(ops_q[3]);
    idle(2);
    wait_obs(4);
    for (int i = 0; i < ops_q.size() && obs_q.size() > 0; i++) begin
      obs_t o;
      o = obs_q.pop_front();
      checks++;
      if ({o.rd, o.c, o.z, o.res} !== {ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er}) begin
        failures++;
        $display("FAIL bp[%0d]: got rd=%0d c=%0b z=%0b res=%h, required rd=%0d c=%0b z=%0b res=%h",
                 i, o.rd, o.c, o.z, o.res, ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er);
      end
    end
  endtask

  task automatic test_reset_midstream();
    obs_q.delete();
    send(mk(OP_ADD, 1'b1, 8'h44, 3'd0, 3'd0, 3'd1, 8'h44, 1'b0, 1'b0));
    send(mk(OP_ADD, 1'b1, 8'h55, 3'd0, 3'd0, 3'd2, 8'h55, 1'b0, 1'b0));
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_rd, out_result} !== 12'd0) begin
      failures++;
      $display("FAIL midreset_out: got v=%0b rd=%0d res=%h, required 0 0 00",
               out_valid, out_rd, out_result);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_discard: got %0d results, required 0", obs_q.size());
    end
    load_zero_reads();
    run_ops();
    for (int i = 0; i < ops_q.size() && obs_q.size() > 0; i++) begin
      obs_t o;
      o = obs_q.pop_front();
      checks++;
      if ({o.rd, o.c, o.z, o.res} !== {ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er}) begin
        failures++;
        $display("FAIL midreset_regs[%0d]: got rd=%0d c=%0b z=%0b res=%h, required rd=%0d c=%0b z=%0b res=%h",
                 i, o.rd, o.c, o.z, o.res, ops_q[i].rd, ops_q[i].ec, ops_q[i].ez, ops_q[i].er);
      end
    end
  endtask

  task automatic test_param();
    logic [2:0]  sel;
    logic        isel;
    logic [15:0] imm, a, b, r;
    logic [16:0] s;
    logic        c;
    logic [3:0]  rs1, rs2, rd;
    logic [21:0] e, g;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    exp_q.delete();
    p_obs_q.delete();
    for (int n = 0; n <= 60; n++) begin
      if (n < 60) begin
        sel  = 3'($urandom_range(0, 7));
        isel = 1'($urandom_range(0, 1));
        imm  = 16'($urandom_range(0, 65535));
        rs1  = 4'($urandom_range(0, 15));
        rs2  = 4'($urandom_range(0, 15));
        rd   = ($urandom_range(0, 1) != 0) ? 4'd15 : 4'($urandom_range(0, 15));
      end else begin
        // final read-back of r15
        sel = OP_OR; isel = 1'b1; imm = 16'h0000; rs1 = 4'd15; rs2 = 4'd0; rd = 4'd0;
      end
      a = mregs[rs1];
      b = isel ? imm : mregs[rs2];
      c = 1'b0;
      case (sel)
        OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
        OP_SUB: begin r = a - b; c = (a >= b); end
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_XOR: r = a ^ b;
        OP_NOT: r = ~a;
        OP_SHL: begin r = {a[14:0], 1'b0}; c = a[15]; end
        default: begin r = {1'b0, a[15:1]}; c = a[0]; end
      endcase
      mregs[rd] = r;
      exp_q.push_back({rd, c, (r == 16'h0000), r});
      send_p(sel, isel, imm, rs1, rs2, rd);
    end
    p_in_valid = 1'b0;
    p_out_ready = 1'b1;
    for (int k = 0; k < 100 && p_obs_q.size() < exp_q.size(); k++) @(negedge clk);
    checks++;
    if (p_obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL p_count: got %0d results, required %0d", p_obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && p_obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = p_obs_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL p_stream[%0d]: got rd=%0d c=%0b z=%0b res=%h, required rd=%0d c=%0b z=%0b res=%h",
                 i, g[21:18], g[17], g[16], g[15:0], e[21:18], e[17], e[16], e[15:0]);
      end
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    stall_cnt = 0;
    test_reset();
    test_reset_write();
    test_forwarding();
    test_flags();
    test_backpressure();
    test_reset_midstream();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_datapath.md
# pipe_datapath

Two-stage pipelined, parametrised successor to the single-cycle mini CPU datapath. Accepts one micro-op per cycle over a valid/ready handshake and reads two operands from an internal register file. It executes one of eight ALU operations and writes the result back to the register file. Result, carry and zero flags are presented on a registered output port with backpressure. Sits between the instruction sequencer (upstream) and the result/flag consumer (downstream).

## Interface
Parameters:
- WIDTH, 8, datapath and register width (≥ 2)
- REG_COUNT, 8, number of registers (power of two, ≥ 2); AW = $clog2(REG_COUNT)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  micro-op present
- in_ready  out  1  micro-op accepted when in_valid && in_ready at the rising edge
- in_alu_sel  in  3  ALU operation
- in_imm_sel  in  1  operand B: 0 = register rs2, 1 = in_imm
- in_imm  in  WIDTH  immediate operand
- in_rs1, in_rs2  in  AW  source register addresses
- in_rd  in  AW  destination register address
- in_we  in  1  write the result to rd
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_result  out  WIDTH  ALU result
- out_carry  out  1  carry flag
- out_zero  out  1  out_result == 0
- out_rd  out  AW  destination of the result

## Operation
- Stage RD, combinational from accepted inputs:
  - Read rs1 and rs2.
  - Apply forwarding.
  - Select operand B.
  - Latch A, B, alu_sel, rd and we into the RD/EX register with ex_valid.
- Stage EX, combinational ALU on the RD/EX register:
  - Latch result, carry, zero and rd into the output register.
  - In the same edge, write the register file if ex_valid && ex_we.
- Advance enable: adv = !out_valid || out_ready.
  - All pipeline registers and the register-file write are gated by adv.
  - When adv = 0, everything holds, including out_* (stable while out_valid && !out_ready).
- in_ready = adv, qualified by the hazard stall when forwarding is compiled out (see Configuration).
- ALU encoding, with A = operand A, B = operand B:
  - 000 ADD: carry = bit WIDTH of A+B.
  - 001 SUB: A-B; carry = 1 when A ≥ B unsigned (no borrow).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 NOT A: carry = 0.
  - 110 SHL A by 1: carry = A[WIDTH-1].
  - 111 SHR A by 1, logical: carry = A[0].
- Arithmetic is modulo 2^WIDTH. The zero flag is computed on the truncated result.
- Register file:
  - REG_COUNT × WIDTH.
  - Register 0 is an ordinary register.
  - Reads are combinational.
- Forwarding: if ex_valid && ex_we && ex_rd == rs, the RD stage uses the current ALU output instead of the register-file value. This is applied independently for rs1 and rs2. rs2 forwarding is irrelevant when in_imm_sel = 1.
- Bubbles: a cycle with adv = 1 and no accepted input loads ex_valid = 0. A bubble never writes the register file and never raises out_valid.

## Timing
- Reset (rst low, asynchronous):
  - All registers 0, including the register file.
  - ex_valid = 0.
  - out_valid = 0; out_result, out_carry, out_zero and out_rd = 0.
  - in_ready = 1 after release.
- Latency: a micro-op accepted at edge k appears on out_* with out_valid = 1 after edge k+1. Its register write also takes effect at edge k+1.
- Throughput: 1 micro-op per cycle while out_ready = 1.
- Back-to-back dependency (op i+1 reads op i's rd): forwarded, zero stall.
- Dependency distance 2: the value has already been written to the register file, so no forwarding is needed.
- Simultaneous write and read of the same register in one cycle: covered by forwarding.
- Backpressure: with out_ready = 0 and out_valid = 1, in_ready = 0 and the pipeline freezes. No write is lost or duplicated.
- Reset mid-operation: in-flight ops are discarded and no partial writes occur.

## Configuration
- PIPE_DATAPATH_FWD_EN defined: forwarding as described; in_ready = adv.
- Undefined: no forwarding paths. When a hazard exists (in_valid && ex_valid && ex_we && (ex_rd == in_rs1 || (!in_imm_sel && ex_rd == in_rs2))), in_ready = 0 for that cycle and a bubble enters EX. The op is accepted next cycle and reads the written value. The dependent op costs 1 extra cycle; results are identical.

## Test plan
- Reset and write: after reset, issue ADD r1 = r0 + imm 5, then ADD r2 = r0 + imm 3. Expect out_result 5 then 3, carry 0, zero 0, one per cycle.
- Forwarding chain: issue ADD r3 = r1 + r2 immediately followed by SUB r4 = r3 − imm 8. Expect 8, then 0 with zero = 1 and carry = 1. With FWD_EN: no stall. Without it: in_ready low exactly 1 cycle.
- Flags (WIDTH = 8): 0xFF + imm 0x01 → result 0x00, carry 1, zero 1. SHL 0x81 → 0x02, carry 1. SHR 0x01 → 0x00, carry 1, zero 1. SUB 0x03 − 0x05 → 0xFE, carry 0.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1. Expect out_* stable, in_ready = 0, and no register writes. On release, results resume in order with none lost or duplicated.
- Asynchronous reset mid-stream: assert rst low between edges with 2 ops in flight. Expect out_valid = 0 immediately and all registers reading 0 afterwards.
- Parametrisation: WIDTH = 16, REG_COUNT = 16. Run random op streams against a reference model, checking results, flags and r15 writes.
